pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/sat_cnt32.sv | 10 +
 rtl/pipe_hazard_ctrl.sv | 66 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int REG_IDX_W = 5;
  localparam int MDU_MAX_CYC_DEF = 32;
  typedef enum logic {RUN, MDU_WAIT} state_t;
endpackage

// File: rtl/sat_cnt32.sv
// sat_cnt32: 32-bit counter with synchronous clear and increment enable, saturating at all-ones.
module sat_cnt32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (en && cnt != '1) ? cnt + 32'd1 : cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for memory wait, multi-cycle MDU, taken branch and load-use hazards.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYC = MDU_MAX_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic                 ex_memread,
  input  logic                 ex_regwrite,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_br_taken,
  input  logic                 ex_mdu_start,
  input  logic                 mdu_done,
  input  logic                 mem_ready,
  output logic                 pc_lock,
  output logic                 ifid_lock,
  output logic                 idex_lock,
  output logic                 exmem_lock,
  output logic                 memwb_lock,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 mdu_timeout,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
);
  state_t state;
  logic [31:0] mdu_cyc;
  logic load_use, wd_exp, mem_hold, mdu_hold, br_fl, lu_st;
  assign load_use = ex_memread && ex_regwrite && ex_rd != '0 &&
                    ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  assign wd_exp   = state == MDU_WAIT && !mdu_done && mdu_cyc >= 32'(MDU_MAX_CYC);
  assign mem_hold = !rst && !mem_ready;
  // MDU stall covers both the issue cycle in RUN and every non-final cycle of MDU_WAIT
  assign mdu_hold = !rst && mem_ready &&
                    (state == MDU_WAIT ? !mdu_done && !wd_exp : ex_mdu_start && !mdu_done);
  assign br_fl    = !rst && mem_ready && state == RUN && !mdu_hold && ex_br_taken;
  assign lu_st    = !rst && mem_ready && state == RUN && !mdu_hold && !ex_br_taken && load_use;
  assign pc_lock     = mem_hold || mdu_hold || lu_st;
  assign ifid_lock   = mem_hold || mdu_hold || lu_st;
  assign idex_lock   = mem_hold || mdu_hold;
  assign exmem_lock  = mem_hold;
  assign memwb_lock  = mem_hold;
  assign ifid_flush  = br_fl;
  assign idex_flush  = br_fl || lu_st;
  assign exmem_flush = mdu_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      mdu_cyc     <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      mdu_cyc <= (state == RUN) ? (mdu_hold ? 32'd1 : mdu_cyc)
               : ((!mem_ready || mdu_hold) && mdu_cyc != '1) ? mdu_cyc + 32'd1 : mdu_cyc;
      if (mem_ready) state <= mdu_hold ? MDU_WAIT : RUN;
      if (mem_ready && wd_exp) mdu_timeout <= 1'b1;
    end
  end
  sat_cnt32 u_stall (.clk(clk), .clr(rst), .en(pc_lock), .cnt(stall_cnt));
  sat_cnt32 u_flush (.clk(clk), .clr(rst), .en(ifid_flush || idex_flush), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven and sequence checks of the hazard controller through an expectation queue.
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_memread, ex_regwrite, ex_br_taken, ex_mdu_start, mdu_done, mem_ready;
  logic pc_lock, ifid_lock, idex_lock, exmem_lock, memwb_lock, ifid_flush, idex_flush, exmem_flush, mdu_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    string nm;
    logic [4:0] rs, rt;
    logic urs, urt, mrd, rwr;
    logic [4:0] rd;
    logic br, st, dn, mr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] exp_q[$];
  string nm_q[$];
  localparam logic [7:0] L = 8'hE1;

  pipe_hazard_ctrl #(.MDU_MAX_CYC(8)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .mem_ready(mem_ready),
    .pc_lock(pc_lock), .ifid_lock(ifid_lock), .idex_lock(idex_lock), .exmem_lock(exmem_lock),
    .memwb_lock(memwb_lock), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input bit lu, input bit br, input bit st,
                              input bit dn, input bit mr, input logic [7:0] exp);
    vec_t v;
    v = '{nm, lu ? 5'd5 : 5'd0, 5'd0, lu, 1'b0, lu, lu, lu ? 5'd5 : 5'd0, br, st, dn, mr, exp};
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit r = 1'b0);
    logic [7:0] act, e;
    string n;
    @(negedge clk);
    rst = r;
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.urs; id_use_rt = v.urt;
    ex_memread = v.mrd; ex_regwrite = v.rwr; ex_rd = v.rd; ex_br_taken = v.br;
    ex_mdu_start = v.st; mdu_done = v.dn; mem_ready = v.mr;
    exp_q.push_back(v.exp); nm_q.push_back(v.nm);
    #1;
    act = {pc_lock, ifid_lock, idex_lock, exmem_lock, memwb_lock, ifid_flush, idex_flush, exmem_flush};
    e = exp_q.pop_front(); n = nm_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: lock/flush got %b required %b", n, act, e);
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    apply(mk("reset", 0, 0, 0, 0, 1, 8'h00), 1'b1);
  endtask

  initial begin
    tbl[0]  = '{"idle",        5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 8'h00};
    tbl[1]  = '{"lu_rs",       5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 0, 1, 8'hC2};
    tbl[2]  = '{"lu_rd0",      5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 0, 1, 8'h00};
    tbl[3]  = '{"lu_rt",       5'd3, 5'd7, 0, 1, 1, 1, 5'd7, 0, 0, 0, 1, 8'hC2};
    tbl[4]  = '{"rt_unused",   5'd3, 5'd7, 1, 0, 1, 1, 5'd7, 0, 0, 0, 1, 8'h00};
    tbl[5]  = '{"no_memread",  5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 0, 0, 1, 8'h00};
    tbl[6]  = '{"no_regwrite", 5'd5, 5'd0, 1, 0, 1, 0, 5'd5, 0, 0, 0, 1, 8'h00};
    tbl[7]  = '{"br_over_lu",  5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 0, 1, 8'h06};
    tbl[8]  = '{"br",          5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 1, 8'h06};
    tbl[9]  = '{"mem_over_br", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 8'hF8};
    tbl[10] = '{"mdu_fast",    5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 8'h00};
    tbl[11] = '{"mdu_fast_lu", 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 1, 1, 1, 8'hC2};

    // reset dominates hazard inputs
    apply(mk("in_reset", 1, 1, 1, 0, 0, 8'h00), 1'b1);
    tick();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_timeout", {31'd0, mdu_timeout}, 0);

    // single load-use bubble
    apply(mk("lu_one", 1, 0, 0, 0, 1, 8'hC2));
    tick();
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_flush_cnt", flush_cnt, 1);
    apply(mk("lu_after", 0, 0, 0, 0, 1, 8'h00));

    do_rst();
    foreach (tbl[i]) apply(tbl[i]);
    tick();
    chk("tbl_stall_cnt", stall_cnt, 4);
    chk("tbl_flush_cnt", flush_cnt, 5);

    // MDU completes four cycles after issue; branch/load-use ignored while waiting
    do_rst();
    apply(mk("mdu_issue", 0, 0, 1, 0, 1, L));
    for (int i = 0; i < 3; i++) apply(mk("mdu_wait", 1, 1, 0, 0, 1, L));
    apply(mk("mdu_done", 0, 0, 0, 1, 1, 8'h00));
    tick();
    chk("mdu_stall_cnt", stall_cnt, 4);
    chk("mdu_flush_cnt", flush_cnt, 0);
    chk("mdu_no_timeout", {31'd0, mdu_timeout}, 0);
    apply(mk("mdu_back_run", 0, 0, 0, 0, 1, 8'h00));

    // watchdog expiry at eight cycles
    do_rst();
    apply(mk("wd_issue", 0, 0, 1, 0, 1, L));
    for (int i = 0; i < 7; i++) apply(mk("wd_wait", 0, 0, 0, 0, 1, L));
    apply(mk("wd_release", 0, 0, 0, 0, 1, 8'h00));
    tick();
    chk("wd_timeout_set", {31'd0, mdu_timeout}, 1);
    chk("wd_stall_cnt", stall_cnt, 8);
    apply(mk("wd_idle", 0, 0, 0, 0, 1, 8'h00));
    apply(mk("wd_idle_lu", 1, 0, 0, 0, 1, 8'hC2));
    tick();
    chk("wd_timeout_sticky", {31'd0, mdu_timeout}, 1);
    do_rst();
    tick();
    chk("wd_timeout_clr", {31'd0, mdu_timeout}, 0);

    // memory stall inside MDU_WAIT, then reset mid-wait
    do_rst();
    apply(mk("mw_issue", 0, 0, 1, 0, 1, L));
    apply(mk("mw_wait", 0, 0, 0, 0, 1, L));
    for (int i = 0; i < 3; i++) apply(mk("mw_mem_stall", 0, 1, 0, 0, 0, 8'hF8));
    apply(mk("mw_still_wait", 1, 1, 0, 0, 1, L));
    apply(mk("mw_rst", 0, 0, 0, 0, 1, 8'h00), 1'b1);
    tick();
    chk("mw_rst_stall_cnt", stall_cnt, 0);
    chk("mw_rst_flush_cnt", flush_cnt, 0);
    apply(mk("mw_late_done", 0, 0, 0, 1, 1, 8'h00));
    apply(mk("mw_run_lu", 1, 0, 0, 0, 1, 8'hC2));
    tick();
    chk("mw_run_stall_cnt", stall_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
